// File: rtl/fifo_ctl_if.sv
// fifo_ctl_if: write/read/status bundle of fifo_ctl; slave is the FIFO, master is the producer/consumer side.
// No clock inside the interface; clk and rst stay plain ports on the FIFO.
interface fifo_ctl_if #(
    parameter int LOG_NUM_SLOTS = 4,
    parameter int DATA_WIDTH    = 32
);
    logic [DATA_WIDTH-1:0]    data_write;
    logic                     write;
    logic                     full;
    logic                     almost_full;
    logic [DATA_WIDTH-1:0]    data_read;
    logic                     next_read;
    logic                     empty;
    logic                     almost_empty;
    logic [LOG_NUM_SLOTS:0]   level;
    logic                     flush;
    logic                     overflow;
    logic                     underflow;
    logic                     clear_err;
    logic [LOG_NUM_SLOTS:0]   max_level;

    modport slave (
        input  data_write, write, next_read, flush, clear_err,
        output full, almost_full, data_read, empty, almost_empty,
               level, overflow, underflow, max_level
    );

    modport master (
        output data_write, write, next_read, flush, clear_err,
        input  full, almost_full, data_read, empty, almost_empty,
               level, overflow, underflow, max_level
    );
endinterface

// File: rtl/fifo_ctl.sv
// fifo_ctl: first-word-fall-through FIFO, write-to-read latency 1; when full a write is refused unless a read pops in the same cycle.
// Sticky overflow/underflow, synchronous flush; define FIFO_PEAK_LEVEL_EN to track peak occupancy on max_level.
module fifo_ctl #(
    parameter int NUM_SLOTS     = 16,
    parameter int LOG_NUM_SLOTS = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int AF_LEVEL      = 12,
    parameter int AE_LEVEL      = 2
) (
    input  logic      clk,
    input  logic      rst,
    fifo_ctl_if.slave bus
);
    localparam logic [LOG_NUM_SLOTS:0]   LVL_FULL = (LOG_NUM_SLOTS+1)'(NUM_SLOTS);
    localparam logic [LOG_NUM_SLOTS:0]   LVL_AF   = (LOG_NUM_SLOTS+1)'(AF_LEVEL);
    localparam logic [LOG_NUM_SLOTS:0]   LVL_AE   = (LOG_NUM_SLOTS+1)'(AE_LEVEL);
    localparam logic [LOG_NUM_SLOTS-1:0] PTR_ONE  = 1;

    logic [DATA_WIDTH-1:0]    r_mem [NUM_SLOTS];
    logic [LOG_NUM_SLOTS-1:0] r_rd_ptr;
    logic [LOG_NUM_SLOTS-1:0] r_wr_ptr;
    logic [LOG_NUM_SLOTS:0]   r_level;
    logic                     r_overflow;
    logic                     r_underflow;

    logic                     w_empty;
    logic                     w_full;
    logic                     w_rd_ok;
    logic                     w_wr_ok;
    logic                     w_ovf_set;
    logic                     w_unf_set;
    logic [LOG_NUM_SLOTS:0]   w_level_nxt;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LVL_FULL);

    // A pop in the same cycle frees the slot a write into a full FIFO needs.
    assign w_rd_ok = bus.next_read & ~w_empty;
    assign w_wr_ok = bus.write & (~w_full | w_rd_ok);

    // Flush swallows the same-cycle requests, so they raise no error either.
    assign w_ovf_set = ~bus.flush & bus.write & ~w_wr_ok;
    assign w_unf_set = ~bus.flush & bus.next_read & w_empty;

    assign w_level_nxt = bus.flush ? '0
                       : r_level + {{LOG_NUM_SLOTS{1'b0}}, w_wr_ok}
                                 - {{LOG_NUM_SLOTS{1'b0}}, w_rd_ok};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_wr_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (w_rd_ok) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_level <= w_level_nxt;

            if (w_ovf_set)          r_overflow <= 1'b1;
            else if (bus.clear_err) r_overflow <= 1'b0;

            if (w_unf_set)          r_underflow <= 1'b1;
            else if (bus.clear_err) r_underflow <= 1'b0;
        end
    end

    // Storage carries no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (rst && !bus.flush && w_wr_ok)
            r_mem[r_wr_ptr] <= bus.data_write;
    end

    assign bus.data_read    = r_mem[r_rd_ptr];
    assign bus.level        = r_level;
    assign bus.empty        = w_empty;
    assign bus.full         = w_full;
    assign bus.almost_full  = (r_level >= LVL_AF);
    assign bus.almost_empty = (r_level <= LVL_AE);
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

`ifdef FIFO_PEAK_LEVEL_EN
    logic [LOG_NUM_SLOTS:0] r_max_level;

    always_ff @(posedge clk) begin
        if (!rst)                           r_max_level <= '0;
        else if (bus.clear_err)             r_max_level <= '0;
        else if (w_level_nxt > r_max_level) r_max_level <= w_level_nxt;
    end

    assign bus.max_level = r_max_level;
`else
    assign bus.max_level = '0;
`endif
endmodule

// File: tb/tb_fifo_ctl.sv
// Self-checking bench for fifo_ctl: a vector table for single-cycle rules, then scoreboarded sequences for fill/drain, wrap, errors, flush and reset.
module tb_fifo_ctl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_ctl_if #(.LOG_NUM_SLOTS(4), .DATA_WIDTH(32)) bus ();

    fifo_ctl #(
        .NUM_SLOTS(16), .LOG_NUM_SLOTS(4), .DATA_WIDTH(32), .AF_LEVEL(12), .AE_LEVEL(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [31:0] sb[$];
    logic        m_ovf;
    logic        m_unf;
    int          m_max;

    typedef struct {
        logic        w, r, fl, ce;
        logic [31:0] d;
        logic [4:0]  lvl;
        logic        emp, ae, af, ful, ovf, unf, cd;
        logic [31:0] dat;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.write      = 1'b0;
        bus.next_read  = 1'b0;
        bus.flush      = 1'b0;
        bus.clear_err  = 1'b0;
        bus.data_write = '0;
    endtask

    task automatic check_state(input string tag);
        int n;
        n = sb.size();
        chk({tag, "_level"}, 32'(bus.level), 32'(n));
        chk({tag, "_empty"}, 32'(bus.empty), 32'(n == 0));
        chk({tag, "_full"},  32'(bus.full),  32'(n == 16));
        chk({tag, "_af"},    32'(bus.almost_full),  32'(n >= 12));
        chk({tag, "_ae"},    32'(bus.almost_empty), 32'(n <= 2));
        chk({tag, "_ovf"},   32'(bus.overflow),  32'(m_ovf));
        chk({tag, "_unf"},   32'(bus.underflow), 32'(m_unf));
`ifdef FIFO_PEAK_LEVEL_EN
        chk({tag, "_max"},   32'(bus.max_level), 32'(m_max));
`else
        chk({tag, "_max"},   32'(bus.max_level), 32'd0);
`endif
    endtask

    // One cycle of stimulus: the model decides acceptance, a popped head is
    // compared against the queue front, and the registered state afterwards.
    task automatic op(input string tag, input logic w, input logic [31:0] d,
                      input logic r, input logic fl, input logic ce);
        logic rd_ok, wr_ok, was_empty;
        bus.write = w; bus.data_write = d; bus.next_read = r;
        bus.flush = fl; bus.clear_err = ce;
        was_empty = (sb.size() == 0);
        rd_ok = r && !was_empty;
        wr_ok = w && (sb.size() != 16 || rd_ok);
        if (fl) begin
            sb.delete();
        end else begin
            if (rd_ok) begin
                chk({tag, "_rdat"}, bus.data_read, sb[0]);
                void'(sb.pop_front());
            end
            if (wr_ok) sb.push_back(d);
        end
        m_ovf = (!fl && w && !wr_ok) ? 1'b1 : (ce ? 1'b0 : m_ovf);
        m_unf = (!fl && r && was_empty) ? 1'b1 : (ce ? 1'b0 : m_unf);
        if (ce) m_max = 0;
        else if (sb.size() > m_max) m_max = sb.size();
        tick();
        idle();
        check_state(tag);
    endtask

    task automatic do_reset(input logic w);
        rst = 1'b0;
        bus.write = w;
        bus.data_write = 32'hDEAD;
        tick();
        rst = 1'b1;
        idle();
        sb.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_max = 0;
    endtask

    initial begin
        idle();
        m_ovf = 1'b0; m_unf = 1'b0; m_max = 0;

        //            w    r    fl   ce   d       lvl emp ae af ful ovf unf cd dat
        tbl[0] = '{1'b0,1'b1,1'b0,1'b0,32'h00,5'd0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,32'h00};
        tbl[1] = '{1'b0,1'b0,1'b0,1'b1,32'h00,5'd0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'h00};
        tbl[2] = '{1'b1,1'b1,1'b0,1'b0,32'h11,5'd1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,32'h11};
        tbl[3] = '{1'b1,1'b0,1'b0,1'b1,32'h22,5'd2,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,32'h11};
        tbl[4] = '{1'b1,1'b0,1'b0,1'b0,32'h33,5'd3,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'h11};
        tbl[5] = '{1'b0,1'b1,1'b0,1'b0,32'h00,5'd2,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,32'h22};
        tbl[6] = '{1'b1,1'b0,1'b1,1'b0,32'h44,5'd0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'h00};
        tbl[7] = '{1'b0,1'b1,1'b0,1'b1,32'h00,5'd0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,32'h00};
        tbl[8] = '{1'b0,1'b0,1'b0,1'b1,32'h00,5'd0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'h00};

        // reset state
        tick(); tick();
        rst = 1'b1;
        #1;
        check_state("rst");

        // single-cycle rules from the vector table
        for (int i = 0; i < 9; i++) begin
            bus.write = tbl[i].w; bus.next_read = tbl[i].r; bus.flush = tbl[i].fl;
            bus.clear_err = tbl[i].ce; bus.data_write = tbl[i].d;
            tick();
            idle();
            chk($sformatf("vec%0d_level", i), 32'(bus.level), 32'(tbl[i].lvl));
            chk($sformatf("vec%0d_empty", i), 32'(bus.empty), 32'(tbl[i].emp));
            chk($sformatf("vec%0d_ae", i), 32'(bus.almost_empty), 32'(tbl[i].ae));
            chk($sformatf("vec%0d_af", i), 32'(bus.almost_full), 32'(tbl[i].af));
            chk($sformatf("vec%0d_full", i), 32'(bus.full), 32'(tbl[i].ful));
            chk($sformatf("vec%0d_ovf", i), 32'(bus.overflow), 32'(tbl[i].ovf));
            chk($sformatf("vec%0d_unf", i), 32'(bus.underflow), 32'(tbl[i].unf));
            if (tbl[i].cd) chk($sformatf("vec%0d_dat", i), bus.data_read, tbl[i].dat);
        end

        // fill, overflow, clear, full write+read, drain
        do_reset(1'b0);
        check_state("rst2");
        for (int i = 1; i <= 16; i++) op("fill", 1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
        op("ovf", 1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
        op("clr", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        op("fullwr", 1'b1, 32'hBEEF, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) op("drain", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // wrap-around
        for (int i = 0; i < 10; i++) op("wrw1", 1'b1, 32'hB0 + 32'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) op("wrr1", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) op("wrw2", 1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) op("wrr2", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // write and read together on an empty FIFO
        op("ewr", 1'b1, 32'h99, 1'b1, 1'b0, 1'b0);
        chk("ewr_dat", bus.data_read, 32'h99);
        op("ewr_rd", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

        // flush overrides a same-cycle write; peak level survives
        do_reset(1'b0);
        for (int i = 0; i < 7; i++) op("fl_fill", 1'b1, 32'h70 + 32'(i), 1'b0, 1'b0, 1'b0);
        op("flush", 1'b1, 32'h66, 1'b0, 1'b1, 1'b0);
        op("fl_wr", 1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
        chk("fl_dat", bus.data_read, 32'h77);
`ifdef FIFO_PEAK_LEVEL_EN
        chk("fl_max", 32'(bus.max_level), 32'd7);
`endif

        // reset mid-stream with a write pending
        for (int i = 0; i < 4; i++) op("rs_fill", 1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0, 1'b0);
        do_reset(1'b1);
        check_state("rst_mid");
        op("rs_w1", 1'b1, 32'hC1, 1'b0, 1'b0, 1'b0);
        op("rs_w2", 1'b1, 32'hC2, 1'b0, 1'b0, 1'b0);
        op("rs_rd", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("rs_head", bus.data_read, 32'hC2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
